// File: rtl/bridge_pkg.sv
// Shared types and helpers for the AHB->APB write-data splitter.
//   state_e     : splitter FSM states
//   HSIZE_*     : AHB HSIZE encodings
//   beat_count  : number of APB beats a transfer of a given size needs
package bridge_pkg;

  typedef enum logic [1:0] {IDLE, BEAT, RESP} state_e;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;
  localparam logic [2:0] HSIZE_128   = 3'd4;
  localparam logic [2:0] HSIZE_256   = 3'd5;
  localparam logic [2:0] HSIZE_512   = 3'd6;
  localparam logic [2:0] HSIZE_1024  = 3'd7;

  // Oversized transfers get zero beats; they are answered as errors.
  function automatic int beat_count(logic [2:0] size, int aby, int pby);
    int nb;
    nb = 1 << size;
    if (nb > aby)  return 0;
    if (nb <= pby) return 1;
    return nb / pby;
  endfunction

endpackage

// File: rtl/strb_lane_gen.sv
// Combinational byte-lane decode for one AHB transfer.
//   addr      in  low address bits (byte offset inside the widest AHB word)
//   size      in  HSIZE
//   wstrb     in  AHB byte strobes
//   mask      out active AHB byte lanes, ANDed with wstrb (0 on size error)
//   size_err  out transfer wider than the AHB bus
//   align_err out address not aligned to the transfer size
module strb_lane_gen #(
  parameter int ABY = 8
) (
  input  logic [6:0]     addr,
  input  logic [2:0]     size,
  input  logic [ABY-1:0] wstrb,
  output logic [ABY-1:0] mask,
  output logic           size_err,
  output logic           align_err
);

  logic [7:0] nb;
  int         off;

  always_comb begin
    nb        = 8'd1 << size;
    size_err  = int'(nb) > ABY;
    // nb[6:0]-1 wraps to 7'h7F for 128-byte transfers, which is the right mask
    align_err = |(addr & (nb[6:0] - 7'd1));
    off       = int'(addr) % ABY;
    mask      = '0;
    for (int i = 0; i < ABY; i++)
      mask[i] = !size_err && (i >= off) && (i < off + int'(nb)) && wstrb[i];
  end

endmodule

// File: rtl/ahb_apb_wdata_splitter.sv
// Splits one latched AHB transfer into 1..N APB-width beats and gathers the
// read data / error status back into a single AHB-width response.
//   HCLK/HRESETn                clock, async active-low reset
//   req_*                       AHB transfer request (accepted in IDLE)
//   beat_*                      per-beat PADDR/PWDATA/PSTRB towards the APB master
//   rsp_*                       transfer completion with gathered PRDATA / error
// Build option: STRB_ZERO_SKIP_EN -- write beats with an all-zero strobe are
// skipped (one idle cycle each); all-zero writes complete with no beats.
module ahb_apb_wdata_splitter
  import bridge_pkg::*;
#(
  parameter int AHB_DW = 64,
  parameter int APB_DW = 32,
  parameter int AW     = 32
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [AW-1:0]       req_addr,
  input  logic [2:0]          req_size,
  input  logic [AHB_DW/8-1:0] req_wstrb,
  input  logic [AHB_DW-1:0]   req_wdata,
  output logic                beat_valid,
  input  logic                beat_ready,
  output logic [AW-1:0]       beat_addr,
  output logic [APB_DW-1:0]   beat_wdata,
  output logic [APB_DW/8-1:0] beat_strb,
  output logic                beat_last,
  input  logic [APB_DW-1:0]   beat_rdata,
  input  logic                beat_err,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_err,
  output logic [AHB_DW-1:0]   rsp_rdata
);

  localparam int ABY = AHB_DW / 8;
  localparam int PBY = APB_DW / 8;
  localparam int CW  = 8;

  state_e            state;
  logic [AW-1:0]     addr_q;
  logic [2:0]        size_q;
  logic              write_q;
  logic [ABY-1:0]    mask_q;
  logic [AHB_DW-1:0] wdata_q;
  logic [CW-1:0]     k_q, nbeats_q;
  logic              beat_valid_q, rsp_valid_q, rsp_err_q;
  logic [AHB_DW-1:0] rdata_q;

  logic [ABY-1:0]    mask_in;
  logic              size_err, align_err;

  strb_lane_gen #(.ABY(ABY)) u_lane (
    .addr      (req_addr[6:0]),
    .size      (req_size),
    .wstrb     (req_wstrb),
    .mask      (mask_in),
    .size_err  (size_err),
    .align_err (align_err)
  );

  // Sub-PBY transfers stay on the request address; wide ones walk by PBY.
  function automatic logic [AW-1:0] beat_addr_f(logic [AW-1:0] a, logic [2:0] s,
                                                logic [CW-1:0] k);
    int nb;
    nb = 1 << s;
    if (nb <= PBY) return a;
    return a + AW'(k) * AW'(PBY);
  endfunction

  function automatic int unsigned lane_off_f(logic [AW-1:0] a);
    return 32'(a % AW'(ABY)) & ~32'(PBY - 1);
  endfunction

  logic [AW-1:0]  cur_addr;
  int unsigned    cur_off;
  logic           cur_last;
  logic           nxt_skip, skip0, skip_all;
`ifdef STRB_ZERO_SKIP_EN
  logic [AW-1:0]  nxt_addr;
`endif

  always_comb begin
    cur_addr = beat_addr_f(addr_q, size_q, k_q);
    cur_off  = lane_off_f(cur_addr);
`ifdef STRB_ZERO_SKIP_EN
    nxt_addr = beat_addr_f(addr_q, size_q, k_q + 1'b1);
    nxt_skip = write_q && (mask_q[lane_off_f(nxt_addr) +: PBY] == '0);
    skip0    = req_write && (mask_in[lane_off_f(req_addr) +: PBY] == '0);
    skip_all = req_write && (mask_in == '0);
    // Writes end on the last beat that still has strobes; beats sit in
    // ascending lane order, so nothing above this beat's lanes means last.
    cur_last = write_q ? ((mask_q >> (cur_off + PBY)) == '0)
                       : (k_q == nbeats_q - 1'b1);
`else
    nxt_skip = 1'b0;
    skip0    = 1'b0;
    skip_all = 1'b0;
    cur_last = (k_q == nbeats_q - 1'b1);
`endif
  end

  assign req_ready  = (state == IDLE);
  assign beat_valid = beat_valid_q;
  assign beat_addr  = cur_addr;
  assign beat_wdata = wdata_q[8*cur_off +: APB_DW];
  assign beat_strb  = write_q ? mask_q[cur_off +: PBY] : '0;
  assign beat_last  = beat_valid_q & cur_last;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rdata_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state        <= IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      write_q      <= 1'b0;
      mask_q       <= '0;
      wdata_q      <= '0;
      k_q          <= '0;
      nbeats_q     <= '0;
      beat_valid_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rdata_q      <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q   <= req_addr;
          size_q   <= req_size;
          write_q  <= req_write;
          mask_q   <= mask_in;
          wdata_q  <= req_wdata;
          k_q      <= '0;
          nbeats_q <= CW'(beat_count(req_size, ABY, PBY));
          if (size_err || align_err) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else if (skip_all) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            state        <= BEAT;
            beat_valid_q <= !skip0;
          end
        end
        BEAT: begin
          if (beat_valid_q) begin
            if (beat_ready) begin
              rsp_err_q <= rsp_err_q | beat_err;
              if (!write_q) rdata_q[8*cur_off +: APB_DW] <= beat_rdata;
              if (cur_last) begin
                state        <= RESP;
                beat_valid_q <= 1'b0;
                rsp_valid_q  <= 1'b1;
              end else begin
                k_q          <= k_q + 1'b1;
                beat_valid_q <= !nxt_skip;
              end
            end
          end else begin
            // skipped beat: burn one cycle and look at the next one
            k_q          <= k_q + 1'b1;
            beat_valid_q <= !nxt_skip;
          end
        end
        RESP: if (rsp_ready) begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rdata_q     <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_apb_wdata_splitter.sv
// Directed bench for ahb_apb_wdata_splitter (AHB_DW=64, APB_DW=32).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ahb_apb_wdata_splitter;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_wstrb;
  logic [63:0] req_wdata;
  logic        beat_valid, beat_ready, beat_last, beat_err;
  logic [31:0] beat_addr, beat_wdata, beat_rdata;
  logic [3:0]  beat_strb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 HCLK = ~HCLK;

  ahb_apb_wdata_splitter #(.AHB_DW(64), .APB_DW(32), .AW(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wstrb(req_wstrb),
    .req_wdata(req_wdata),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
    .beat_wdata(beat_wdata), .beat_strb(beat_strb), .beat_last(beat_last),
    .beat_rdata(beat_rdata), .beat_err(beat_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic w, input logic [31:0] a, input logic [2:0] s,
                          input logic [7:0] st, input logic [63:0] d);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_write = w; req_addr = a; req_size = s;
    req_wstrb = st; req_wdata = d;
    @(negedge HCLK);
    req_valid = 0;
  endtask

  task automatic do_beat(input string tag, input logic [31:0] ea, input logic cw,
                         input logic [31:0] ed, input logic [3:0] es, input logic el,
                         input logic [31:0] rd, input logic er);
    int n = 0;
    while (!beat_valid && n < 20) begin @(negedge HCLK); n++; end
    chk({tag, "_seen"}, beat_valid, 1);
    chk({tag, "_addr"}, beat_addr, ea);
    if (cw) chk({tag, "_wdata"}, beat_wdata, ed);
    chk({tag, "_strb"}, beat_strb, es);
    chk({tag, "_last"}, beat_last, el);
    chk({tag, "_req_ready"}, req_ready, 0);
    beat_ready = 1; beat_rdata = rd; beat_err = er;
    @(negedge HCLK);
    beat_ready = 0; beat_err = 0; beat_rdata = '0;
  endtask

  task automatic finish_rsp(input string tag, input logic ee, input logic [63:0] ed);
    int n = 0;
    while (!rsp_valid && n < 20) begin @(negedge HCLK); n++; end
    chk({tag, "_rsp_seen"}, rsp_valid, 1);
    chk({tag, "_no_beat"}, beat_valid, 0);
    chk({tag, "_rsp_err"}, rsp_err, ee);
    chk({tag, "_rsp_rdata"}, rsp_rdata, ed);
    rsp_ready = 1;
    @(negedge HCLK);
    rsp_ready = 0;
    chk({tag, "_rsp_drop"}, rsp_valid, 0);
    chk({tag, "_ready_back"}, req_ready, 1);
  endtask

  initial begin
    HRESETn = 0; req_valid = 0; req_write = 0; req_addr = '0; req_size = '0;
    req_wstrb = '0; req_wdata = '0; beat_ready = 0; beat_rdata = '0;
    beat_err = 0; rsp_ready = 0;
    repeat (2) @(negedge HCLK);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_beat_valid", beat_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    HRESETn = 1;
    @(negedge HCLK);

    // 1: 64-bit write split into two words
    send_req(1, 32'h100, 3'd3, 8'hFF, 64'h1122334455667788);
    chk("t1_vld_rise", beat_valid, 1);
    do_beat("t1b0", 32'h100, 1, 32'h55667788, 4'hF, 0, 0, 0);
    do_beat("t1b1", 32'h104, 1, 32'h11223344, 4'hF, 1, 0, 0);
    finish_rsp("t1", 0, 0);

    // 2: narrow writes
    send_req(1, 32'h103, 3'd0, 8'hFF, 64'h1122334455667788);
    do_beat("t2a", 32'h103, 1, 32'h55667788, 4'h8, 1, 0, 0);
    finish_rsp("t2a", 0, 0);
    send_req(1, 32'h106, 3'd1, 8'hFF, 64'h1122334455667788);
    do_beat("t2b", 32'h106, 1, 32'h11223344, 4'hC, 1, 0, 0);
    finish_rsp("t2b", 0, 0);

    // 3: size and alignment errors
    send_req(1, 32'h100, 3'd4, 8'hFF, 64'h0);
    chk("t3a_no_beat", beat_valid, 0);
    chk("t3a_rsp_next", rsp_valid, 1);
    finish_rsp("t3a", 1, 0);
    send_req(0, 32'h102, 3'd2, 8'h00, 64'h0);
    chk("t3b_no_beat", beat_valid, 0);
    chk("t3b_rsp_next", rsp_valid, 1);
    finish_rsp("t3b", 1, 0);

    // 4: read gather with slave error on second beat
    send_req(0, 32'h200, 3'd3, 8'h00, 64'h0);
    do_beat("t4b0", 32'h200, 0, 0, 4'h0, 0, 32'hAAAA0000, 0);
    do_beat("t4b1", 32'h204, 0, 0, 4'h0, 1, 32'hBBBB1111, 1);
    finish_rsp("t4", 1, 64'hBBBB1111AAAA0000);

    // 5: back-pressure on beat and response
    send_req(1, 32'h300, 3'd3, 8'hFF, 64'hCAFEF00DDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_vld", beat_valid, 1);
      chk("t5_hold_addr", beat_addr, 32'h300);
      chk("t5_hold_wdata", beat_wdata, 32'hDEADBEEF);
      chk("t5_hold_strb", beat_strb, 4'hF);
      chk("t5_hold_rdy", req_ready, 0);
      @(negedge HCLK);
    end
    do_beat("t5b0", 32'h300, 1, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_beat("t5b1", 32'h304, 1, 32'hCAFEF00D, 4'hF, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_rsp_hold", rsp_valid, 1);
      chk("t5_rsp_rdy", req_ready, 0);
      @(negedge HCLK);
    end
    finish_rsp("t5", 0, 0);

    // 6: upper-half-only write, and an all-zero-strobe write
    send_req(1, 32'h100, 3'd3, 8'hF0, 64'h1122334455667788);
`ifdef STRB_ZERO_SKIP_EN
    chk("t6_skip_cycle", beat_valid, 0);
    @(negedge HCLK);
    do_beat("t6b1", 32'h104, 1, 32'h11223344, 4'hF, 1, 0, 0);
    finish_rsp("t6", 0, 0);
    send_req(1, 32'h108, 3'd3, 8'h00, 64'h0);
    chk("t6z_no_beat", beat_valid, 0);
    chk("t6z_rsp_next", rsp_valid, 1);
    finish_rsp("t6z", 0, 0);
`else
    do_beat("t6b0", 32'h100, 1, 32'h55667788, 4'h0, 0, 0, 0);
    do_beat("t6b1", 32'h104, 1, 32'h11223344, 4'hF, 1, 0, 0);
    finish_rsp("t6", 0, 0);
    send_req(1, 32'h108, 3'd3, 8'h00, 64'h0);
    do_beat("t6zb0", 32'h108, 1, 32'h0, 4'h0, 0, 0, 0);
    do_beat("t6zb1", 32'h10C, 1, 32'h0, 4'h0, 1, 0, 0);
    finish_rsp("t6z", 0, 0);
`endif

    // reset in the middle of a beat
    send_req(1, 32'h400, 3'd3, 8'hFF, 64'h0123456789ABCDEF);
    chk("rm_vld_before", beat_valid, 1);
    HRESETn = 0;
    #1;
    chk("rm_beat_valid", beat_valid, 0);
    chk("rm_beat_addr", beat_addr, 0);
    chk("rm_beat_wdata", beat_wdata, 0);
    chk("rm_beat_strb", beat_strb, 0);
    chk("rm_beat_last", beat_last, 0);
    chk("rm_rsp_valid", rsp_valid, 0);
    chk("rm_rsp_err", rsp_err, 0);
    chk("rm_rsp_rdata", rsp_rdata, 0);
    @(negedge HCLK);
    HRESETn = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk("rm_no_rsp", rsp_valid, 0);
      chk("rm_no_beat", beat_valid, 0);
      chk("rm_idle", req_ready, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
